iir_cfg_ctrl: RTL and testbench

// Sequencer/configurator in front of one IIR core (8-bit Q4.4 sample x, coefficients a,b,c,d; core advances every clk).

---
 rtl/iir_cfg_ctrl_pkg.sv | 26 ++
 rtl/iir_valid_pipe.sv | 26 ++
 rtl/iir_cfg_ctrl.sv | 159 +++++++++++++++
 tb/tb_iir_cfg_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/iir_cfg_ctrl_pkg.sv
// Shared types for the IIR configuration controller: Q4.4 width, coefficient
// addresses and the commit sequencer states.
package iir_cfg_ctrl_pkg;

  localparam int Q_W = 8;

  typedef logic [Q_W-1:0] q44_t;

  typedef enum logic [1:0] {
    COEF_A = 2'd0,
    COEF_B = 2'd1,
    COEF_C = 2'd2,
    COEF_D = 2'd3
  } coef_addr_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/iir_valid_pipe.sv
// Valid-tag shift register that tracks accepted samples through the core.
// vld_o is vld_i delayed DEPTH+1 cycles; clr_i empties the pipe on the next edge.
module iir_valid_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic vld_i,
  output logic vld_o
);

  logic [DEPTH:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d = clr_i ? '0 : {pipe_q[DEPTH-1:0], vld_i};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pipe_q <= '0;
    else      pipe_q <= pipe_d;
  end

  assign vld_o = pipe_q[DEPTH];

endmodule

// File: rtl/iir_cfg_ctrl.sv
// Paces samples into an always-running IIR core and sequences coefficient commits:
// drain in-flight samples, load active bank from shadow, then hold the core in reset.
module iir_cfg_ctrl
  import iir_cfg_ctrl_pkg::*;
#(
  parameter int          LATENCY   = 1,
  parameter int          FLUSH_CYC = 2,
  parameter logic [7:0]  A_INIT    = 8'h08,
  parameter logic [7:0]  B_INIT    = 8'hE8,
  parameter logic [7:0]  C_INIT    = 8'h20,
  parameter logic [7:0]  D_INIT    = 8'hF0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  input  logic       cfg_commit,
  output logic       cfg_busy,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       iir_rst_n,
  output logic [7:0] iir_a,
  output logic [7:0] iir_b,
  output logic [7:0] iir_c,
  output logic [7:0] iir_d,
  output logic [7:0] iir_x,
  input  logic [7:0] iir_y
);

  localparam int CNT_MAX = max2(LATENCY + 1, FLUSH_CYC);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(LATENCY + 1);
  localparam logic [CNT_W-1:0] FLUSH_LD = CNT_W'(FLUSH_CYC);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             flush_q, flush_d;
  logic             load_act;
  logic             vpipe_clr;
  logic             accept;
  q44_t             x_q, x_d;
  q44_t             shadow_q [4];
  q44_t             shadow_d [4];
  q44_t             active_q [4];
  q44_t             active_d [4];
  coef_addr_e       waddr;

  assign waddr  = coef_addr_e'(cfg_addr);
  assign accept = in_valid & in_ready;
  assign x_d    = accept ? in_data : '0;

  // Shadow writes land immediately; active only moves on entry to FLUSH.
  always_comb begin
    shadow_d = shadow_q;
    if (cfg_we) shadow_d[waddr] = cfg_wdata;
    active_d = load_act ? shadow_q : active_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    load_act  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (cfg_commit || pending_q) begin
          state_d   = ST_DRAIN;
          cnt_d     = DRAIN_LD;
          pending_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (cfg_commit) pending_d = 1'b1;
        if (cnt_q == CNT_ONE) begin
          state_d  = ST_FLUSH;
          cnt_d    = FLUSH_LD;
          load_act = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_FLUSH: begin
        if (cfg_commit) pending_d = 1'b1;
        if (cnt_q == CNT_ONE) begin
          pending_d = 1'b0;
          if (pending_q || cfg_commit) begin
            state_d = ST_DRAIN;
            cnt_d   = DRAIN_LD;
          end else begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_RUN) & ~pending_q;
    cfg_busy  = (state_q != ST_RUN) | pending_q;
    vpipe_clr = (state_q == ST_DRAIN) & (state_d == ST_FLUSH);
    flush_d   = (state_d == ST_FLUSH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      flush_q     <= 1'b0;
      x_q         <= '0;
      shadow_q[0] <= A_INIT;
      shadow_q[1] <= B_INIT;
      shadow_q[2] <= C_INIT;
      shadow_q[3] <= D_INIT;
      active_q[0] <= A_INIT;
      active_q[1] <= B_INIT;
      active_q[2] <= C_INIT;
      active_q[3] <= D_INIT;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      flush_q   <= flush_d;
      x_q       <= x_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
    end
  end

  iir_valid_pipe #(.DEPTH(LATENCY)) u_vpipe (
    .clk   (clk),
    .rst   (rst),
    .clr_i (vpipe_clr),
    .vld_i (accept),
    .vld_o (out_valid)
  );

  assign out_data  = iir_y;
  assign iir_rst_n = rst & ~flush_q;
  assign iir_x     = x_q;
  assign iir_a     = active_q[COEF_A];
  assign iir_b     = active_q[COEF_B];
  assign iir_c     = active_q[COEF_C];
  assign iir_d     = active_q[COEF_D];

endmodule

// File: tb/tb_iir_cfg_ctrl.sv
// Bench for iir_cfg_ctrl: a toy one-cycle core (y = x ^ a ^ b ^ c ^ d) feeds iir_y,
// so every response encodes the sample and the coefficient set it was processed with.
module tb_iir_cfg_ctrl;

  localparam int LAT = 1;
  localparam int FL  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_we = 1'b0, cfg_commit = 1'b0, in_valid = 1'b0;
  logic [1:0] cfg_addr = 2'd0;
  logic [7:0] cfg_wdata = 8'h00, in_data = 8'h00;
  logic       cfg_busy, in_ready, out_valid, iir_rst_n;
  logic [7:0] out_data, iir_a, iir_b, iir_c, iir_d, iir_x, iir_y;

  iir_cfg_ctrl #(.LATENCY(LAT), .FLUSH_CYC(FL)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .iir_rst_n(iir_rst_n),
    .iir_a(iir_a), .iir_b(iir_b), .iir_c(iir_c), .iir_d(iir_d), .iir_x(iir_x), .iir_y(iir_y)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] core_y;
  always @(posedge clk or negedge iir_rst_n) begin
    if (!iir_rst_n) core_y <= 8'h00;
    else            core_y <= iir_x ^ iir_a ^ iir_b ^ iir_c ^ iir_d;
  end
  assign iir_y = core_y;

  typedef struct {
    int         cyc;
    logic [7:0] dat;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_sh [4];
  logic [7:0] m_act[4];
  logic       prev_acc = 1'b0;
  logic [7:0] prev_d = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] cx();
    return m_act[0] ^ m_act[1] ^ m_act[2] ^ m_act[3];
  endfunction

  task automatic model_reset();
    m_sh[0] = 8'h08; m_sh[1] = 8'hE8; m_sh[2] = 8'h20; m_sh[3] = 8'hF0;
    m_act = m_sh;
    sbq.delete();
    prev_acc = 1'b0;
  endtask

  // Scoreboard monitor: every out_valid must match the oldest outstanding sample.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (out_valid) begin
        if (sbq.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
        else begin
          e = sbq.pop_front();
          chk("out_cycle", cyc, e.cyc);
          chk("out_data", out_data, e.dat);
        end
      end else if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        chk("missing_out_valid", 32'd0, 32'd1);
        void'(sbq.pop_front());
      end
    end
  end

  // One cycle of stimulus; also checks iir_x against what the previous cycle offered.
  task automatic step(input logic v, input logic [7:0] d, input logic we,
                      input logic [1:0] a, input logic [7:0] wd, input logic cm);
    @(negedge clk);
    chk("iir_x", iir_x, prev_acc ? prev_d : 8'h00);
    in_valid = v; in_data = d; cfg_we = we; cfg_addr = a; cfg_wdata = wd; cfg_commit = cm;
    prev_acc = v & in_ready;
    prev_d   = d;
    if (prev_acc) sbq.push_back('{cyc + 1 + LAT, d ^ cx()});
    if (we) m_sh[a] = wd;
    if (cm) m_act = m_sh;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0);
  endtask

  // Offer random samples until in_ready returns; count stalled, flush and busy cycles.
  task automatic wait_ready(input int budget, output int nr, output int rl,
                            output int bn, output logic [7:0] fa);
    nr = 0; rl = 0; bn = 0; fa = 8'hXX;
    for (int i = 0; i < budget; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 2'd0, 8'h00, 1'b0);
      if (in_ready) return;
      nr++;
      if (cfg_busy) bn++;
      if (!iir_rst_n) begin
        if (rl == 0) fa = iir_a;
        rl++;
      end
    end
    chk("in_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_cfg_busy", cfg_busy, 1'b0);
    chk("rst_iir_rst_n", iir_rst_n, 1'b0);
    chk("rst_iir_x", iir_x, 8'h00);
    chk("rst_coefs", {iir_a, iir_b, iir_c, iir_d}, 32'h08E820F0);
  endtask

  initial begin
    int nr, rl, bn;
    logic [7:0] fa;
    model_reset();

    // 1: reset values, then a steady ramp
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    @(negedge clk) rst = 1'b1;
    #1 chk("iir_rst_n_release", iir_rst_n, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(16 * i), 1'b0, 2'd0, 8'h00, 1'b0);
      chk("s1_in_ready", in_ready, 1'b1);
    end

    // 2: alternating valid
    for (int i = 0; i < 12; i++) step(1'(i % 2 == 0), 8'($urandom), 1'b0, 2'd0, 8'h00, 1'b0);
    repeat (3) idle();

    // 3: single commit with a sample offered in the same cycle
    step(1'b0, 8'h00, 1'b1, 2'd0, 8'h10, 1'b0);
    step(1'b1, 8'h5A, 1'b0, 2'd0, 8'h00, 1'b1);
    chk("s3_a_before", iir_a, 8'h08);
    wait_ready(20, nr, rl, bn, fa);
    chk("s3_stall_cycles", nr, LAT + 1 + FL);
    chk("s3_flush_cycles", rl, FL);
    chk("s3_a_at_flush", fa, 8'h10);
    chk("s3_busy_cycles", bn, LAT + 1 + FL);
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0, 2'd0, 8'h00, 1'b0);

    // 4: second commit while draining
    step(1'b1, 8'hC3, 1'b0, 2'd0, 8'h00, 1'b1);
    step(1'b1, 8'h11, 1'b1, 2'd1, 8'h33, 1'b1);
    chk("s4_ready_in_drain", in_ready, 1'b0);
    chk("s4_busy_in_drain", cfg_busy, 1'b1);
    wait_ready(30, nr, rl, bn, fa);
    chk("s4_stall_cycles", nr + 1, 2 * (LAT + 1 + FL));
    chk("s4_flush_cycles", rl, 2 * FL);
    chk("s4_busy_cycles", bn, nr);
    chk("s4_b", iir_b, 8'h33);
    chk("s4_busy_after", cfg_busy, 1'b0);

    // 5: write and commit in the same cycle
    step(1'b1, 8'h77, 1'b1, 2'd3, 8'hFF, 1'b1);
    wait_ready(20, nr, rl, bn, fa);
    chk("s5_stall_cycles", nr, LAT + 1 + FL);
    chk("s5_coefs", {iir_a, iir_b, iir_c, iir_d}, 32'h103320FF);
    for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), 1'b0, 2'd0, 8'h00, 1'b0);

    // 6: asynchronous reset in the middle of FLUSH
    step(1'b0, 8'h00, 1'b1, 2'd2, 8'h44, 1'b1);
    for (int i = 0; i < 10 && iir_rst_n; i++) idle();
    chk("s6_reached_flush", iir_rst_n, 1'b0);
    #2 rst = 1'b0;
    #1 check_reset_outputs();
    model_reset();
    in_valid = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0;
    @(negedge clk) rst = 1'b1;
    #1 chk("s6_ready_after", in_ready, 1'b1);
    chk("s6_iir_rst_n_after", iir_rst_n, 1'b1);

    // random traffic with occasional write+commit while idle
    for (int i = 0; i < 200; i++) begin
      if (!cfg_busy && $urandom_range(0, 19) == 0)
        step(1'($urandom_range(0, 1)), 8'($urandom), 1'b1, 2'($urandom), 8'($urandom), 1'b1);
      else
        step(1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 2'd0, 8'h00, 1'b0);
    end
    repeat (10) idle();
    chk("scoreboard_empty", sbq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
